// File: rtl/pixel_source_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_source_arbiter
//
// Purpose:
//   Output selector between the camera pipeline stages and the SDRAM
//   frame-buffer write ports. One pixel source is chosen per frame. The
//   sources are raw RGB, gray, histogram image, threshold image and
//   cumulative histogram. The chosen pixel is re-packed into the two 16-bit
//   SDRAM write words.
//
//   The mode register only loads while iFval is low. A frame is therefore
//   never built from two different sources.
//
// Optional feature (compile-time macro):
//   ARBITRATOR_HIST_MARKER_EN
//     When defined, histogram mode draws a pure red vertical marker at the
//     column equal to iThresholdLevel.
//     When undefined, histogram mode is a plain gray image of iHist, and
//     iThresholdLevel is ignored.
//
// Parameters:
//   RESET_MODE       mode register value after reset (000 = invalid, red screen)
//
// Ports:
//   iClk             system clock; all logic on the rising edge
//   iRst_n           synchronous, active-low reset
//   iFval            frame valid; high during the active frame
//   iSelect[2:0]     mode select: 001 RGB, 010 gray, 011 hist, 100 thresh,
//                    101 cum-hist; all other codes are invalid
//   iX_Cont[15:0]    current pixel column (used by the histogram marker)
//   iY_Cont[15:0]    current pixel row (reserved, unused)
//   iRGB_R/G/B[11:0] RGB pixel components;  iRGB_Valid  RGB pixel valid
//   iGray[7:0]       grayscale pixel;       iGray_Valid gray pixel valid
//   iHist[7:0]       histogram-image pixel; iHist_Valid also qualifies iCumHist
//   iThresholdLevel  threshold level (column of the marker)
//   iThresh[7:0]     thresholded pixel;     iThresh_Valid thresholded pixel valid
//   iCumHist[7:0]    cumulative-histogram pixel
//   oWr1_data[15:0]  {1'b0, G[11:7], B[11:2]}
//   oWr2_data[15:0]  {1'b0, G[6:2],  R[11:2]}
//   oWr_data_valid   write strobe for both words
// ---------------------------------------------------------------------------
module pixel_source_arbiter #(
    parameter logic [2:0] RESET_MODE = 3'b000
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iFval,
    input  logic [2:0]  iSelect,
    input  logic [15:0] iX_Cont,
    input  logic [15:0] iY_Cont,
    input  logic [11:0] iRGB_R,
    input  logic [11:0] iRGB_G,
    input  logic [11:0] iRGB_B,
    input  logic        iRGB_Valid,
    input  logic [7:0]  iGray,
    input  logic        iGray_Valid,
    input  logic [7:0]  iHist,
    input  logic [7:0]  iThresholdLevel,
    input  logic        iHist_Valid,
    input  logic [7:0]  iThresh,
    input  logic        iThresh_Valid,
    input  logic [7:0]  iCumHist,
    output logic [15:0] oWr1_data,
    output logic [15:0] oWr2_data,
    output logic        oWr_data_valid
);

    localparam logic [2:0] MODE_RGB     = 3'b001;
    localparam logic [2:0] MODE_GRAY    = 3'b010;
    localparam logic [2:0] MODE_HIST    = 3'b011;
    localparam logic [2:0] MODE_THRESH  = 3'b100;
    localparam logic [2:0] MODE_CUMHIST = 3'b101;

    logic [2:0]  mode_reg;

    logic [11:0] sel_r;
    logic [11:0] sel_g;
    logic [11:0] sel_b;
    logic        sel_valid;
    logic        mode_ok;

    logic [15:0] wr1_next;
    logic [15:0] wr2_next;
    logic        valid_next;

    // The mode register loads only between frames. It holds its value for
    // as long as iFval stays high.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            mode_reg <= RESET_MODE;
        end else if (!iFval) begin
            mode_reg <= iSelect;
        end
    end

    // Source selection. Any 8-bit source is widened to 12 bits as
    // {p, 4'b0000} and is driven onto all three channels, so it shows as gray.
    // The defaults give the invalid-mode picture: solid red, never strobed.
    always_comb begin
        sel_r     = 12'hFFF;
        sel_g     = 12'h000;
        sel_b     = 12'h000;
        sel_valid = 1'b0;
        mode_ok   = 1'b0;
        case (mode_reg)
            MODE_RGB: begin
                sel_r     = iRGB_R;
                sel_g     = iRGB_G;
                sel_b     = iRGB_B;
                sel_valid = iRGB_Valid;
                mode_ok   = 1'b1;
            end
            MODE_GRAY: begin
                sel_r     = {iGray, 4'b0000};
                sel_g     = {iGray, 4'b0000};
                sel_b     = {iGray, 4'b0000};
                sel_valid = iGray_Valid;
                mode_ok   = 1'b1;
            end
            MODE_HIST: begin
                sel_r     = {iHist, 4'b0000};
                sel_g     = {iHist, 4'b0000};
                sel_b     = {iHist, 4'b0000};
                sel_valid = iHist_Valid;
                mode_ok   = 1'b1;
`ifdef ARBITRATOR_HIST_MARKER_EN
                // A red vertical line at the threshold column. The strobe is
                // left untouched so that the marker is written like any pixel.
                if (iX_Cont == {8'h00, iThresholdLevel}) begin
                    sel_r = 12'hFFF;
                    sel_g = 12'h000;
                    sel_b = 12'h000;
                end
`endif
            end
            MODE_THRESH: begin
                sel_r     = {iThresh, 4'b0000};
                sel_g     = {iThresh, 4'b0000};
                sel_b     = {iThresh, 4'b0000};
                sel_valid = iThresh_Valid;
                mode_ok   = 1'b1;
            end
            MODE_CUMHIST: begin
                // The cumulative histogram has no strobe of its own. It
                // shares iHist_Valid with the histogram image.
                sel_r     = {iCumHist, 4'b0000};
                sel_g     = {iCumHist, 4'b0000};
                sel_b     = {iCumHist, 4'b0000};
                sel_valid = iHist_Valid;
                mode_ok   = 1'b1;
            end
            default: begin
                sel_r     = 12'hFFF;
                sel_g     = 12'h000;
                sel_b     = 12'h000;
                sel_valid = 1'b0;
                mode_ok   = 1'b0;
            end
        endcase
    end

    // Word packing. In a valid mode with no valid pixel, both words are
    // black. The invalid modes always show red, whatever the source strobes.
    always_comb begin
        wr1_next   = {1'b0, sel_g[11:7], sel_b[11:2]};
        wr2_next   = {1'b0, sel_g[6:2],  sel_r[11:2]};
        valid_next = mode_ok & sel_valid & iFval;
        if (mode_ok && !sel_valid) begin
            wr1_next = 16'h0000;
            wr2_next = 16'h0000;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oWr1_data      <= 16'h0000;
            oWr2_data      <= 16'h0000;
            oWr_data_valid <= 1'b0;
        end else begin
            oWr1_data      <= wr1_next;
            oWr2_data      <= wr2_next;
            oWr_data_valid <= valid_next;
        end
    end

    // The row counter is reserved. The two low bits of each channel drop
    // out in the 16-bit packing.
    logic unused_bits;
    assign unused_bits = ^{iY_Cont, iX_Cont, iThresholdLevel,
                           sel_r[1:0], sel_g[1:0], sel_b[1:0]};

endmodule

// File: tb/tb_pixel_source_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pixel_source_arbiter
//
// Directed testbench for pixel_source_arbiter. Each step drives the inputs
// just after a rising edge, waits one edge, then compares all three outputs
// against values worked out by hand from the packing formulas:
//   oWr1 = {0, G[11:7], B[11:2]}
//   oWr2 = {0, G[6:2],  R[11:2]}
// ---------------------------------------------------------------------------
module tb_pixel_source_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fval;
    logic [2:0]  sel;
    logic [15:0] x_cont;
    logic [15:0] y_cont;
    logic [11:0] rgb_r, rgb_g, rgb_b;
    logic        rgb_valid;
    logic [7:0]  gray;
    logic        gray_valid;
    logic [7:0]  hist;
    logic [7:0]  thr_level;
    logic        hist_valid;
    logic [7:0]  thresh;
    logic        thresh_valid;
    logic [7:0]  cum_hist;
    logic [15:0] wr1;
    logic [15:0] wr2;
    logic        wr_valid;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    pixel_source_arbiter #(.RESET_MODE(3'b000)) dut (
        .iClk            (clk),
        .iRst_n          (rst_n),
        .iFval           (fval),
        .iSelect         (sel),
        .iX_Cont         (x_cont),
        .iY_Cont         (y_cont),
        .iRGB_R          (rgb_r),
        .iRGB_G          (rgb_g),
        .iRGB_B          (rgb_b),
        .iRGB_Valid      (rgb_valid),
        .iGray           (gray),
        .iGray_Valid     (gray_valid),
        .iHist           (hist),
        .iThresholdLevel (thr_level),
        .iHist_Valid     (hist_valid),
        .iThresh         (thresh),
        .iThresh_Valid   (thresh_valid),
        .iCumHist        (cum_hist),
        .oWr1_data       (wr1),
        .oWr2_data       (wr2),
        .oWr_data_valid  (wr_valid)
    );

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all three outputs against the expected triple.
    task automatic check_out(input string tag, input logic [15:0] e1, input logic [15:0] e2, input logic ev);
        check_value({tag, ".wr1"}, wr1, e1);
        check_value({tag, ".wr2"}, wr2, e2);
        check_value({tag, ".valid"}, {15'd0, wr_valid}, {15'd0, ev});
    endtask

    initial begin
        rst_n = 1'b0; fval = 1'b0; sel = 3'b000;
        x_cont = 16'h0000; y_cont = 16'h0000;
        rgb_r = 12'h000; rgb_g = 12'h000; rgb_b = 12'h000; rgb_valid = 1'b0;
        gray = 8'h00; gray_valid = 1'b0;
        hist = 8'h00; thr_level = 8'h00; hist_valid = 1'b0;
        thresh = 8'h00; thresh_valid = 1'b0; cum_hist = 8'h00;

        tick(); tick();
        check_out("reset", 16'h0000, 16'h0000, 1'b0);

        // Invalid mode 000 shows red.
        rst_n = 1'b1;
        tick();
        check_out("mode000_red", 16'h0000, 16'h03FF, 1'b0);

        // RGB mode with no pixel strobe shows black.
        sel = 3'b001;
        tick(); tick();
        check_out("rgb_novalid", 16'h0000, 16'h0000, 1'b0);

        // RGB pixel inside the frame.
        fval = 1'b1; rgb_valid = 1'b1;
        rgb_r = 12'h000; rgb_g = 12'hFFF; rgb_b = 12'hF0F;
        tick();
        check_out("rgb_pixel", 16'h7FC3, 16'h7C00, 1'b1);

        // A select change mid-frame is ignored.
        sel = 3'b010; gray = 8'h0F; gray_valid = 1'b1;
        tick();
        check_out("midframe_hold", 16'h7FC3, 16'h7C00, 1'b1);

        // A one-cycle iFval gap captures the new mode. The strobe drops during the gap.
        fval = 1'b0;
        tick();
        check_out("fval_gap", 16'h7FC3, 16'h7C00, 1'b0);
        fval = 1'b1;
        tick();
        check_out("gray_pixel", 16'h043C, 16'h703C, 1'b1);

        gray_valid = 1'b0;
        tick();
        check_out("gray_black", 16'h0000, 16'h0000, 1'b0);
        gray_valid = 1'b1;

        // Histogram mode.
        sel = 3'b011; fval = 1'b0;
        tick();
        fval = 1'b1; hist = 8'h80; hist_valid = 1'b1;
        thr_level = 8'h40; x_cont = 16'h0040;
        tick();
`ifdef ARBITRATOR_HIST_MARKER_EN
        check_out("hist_marker", 16'h0000, 16'h03FF, 1'b1);
`else
        check_out("hist_marker_col", 16'h4200, 16'h0200, 1'b1);
`endif
        x_cont = 16'h0041;
        tick();
        check_out("hist_plain", 16'h4200, 16'h0200, 1'b1);

        // Cumulative histogram shares the iHist_Valid strobe.
        sel = 3'b101; fval = 1'b0;
        tick();
        fval = 1'b1; cum_hist = 8'hFF; hist = 8'h00;
        tick();
        check_out("cumhist", 16'h7FFC, 16'h73FC, 1'b1);

        // Threshold image.
        sel = 3'b100; fval = 1'b0;
        tick();
        fval = 1'b1; thresh = 8'hFF; thresh_valid = 1'b1; cum_hist = 8'h00;
        tick();
        check_out("thresh", 16'h7FFC, 16'h73FC, 1'b1);
        thresh_valid = 1'b0;
        tick();
        check_out("thresh_black", 16'h0000, 16'h0000, 1'b0);

        // Invalid code 110 is red and never strobes, even with every source valid.
        sel = 3'b110; fval = 1'b0;
        tick();
        fval = 1'b1; thresh_valid = 1'b1;
        tick();
        check_out("mode110_red", 16'h0000, 16'h03FF, 1'b0);

        // Reset mid-frame in RGB mode.
        sel = 3'b001; fval = 1'b0;
        tick();
        fval = 1'b1;
        tick();
        check_out("rgb_again", 16'h7FC3, 16'h7C00, 1'b1);
        rst_n = 1'b0;
        tick();
        check_out("midframe_reset", 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("post_reset_red", 16'h0000, 16'h03FF, 1'b0);
        tick();
        check_out("post_reset_hold", 16'h0000, 16'h03FF, 1'b0);
        fval = 1'b0;
        tick();
        fval = 1'b1;
        tick();
        check_out("post_reset_rgb", 16'h7FC3, 16'h7C00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
